// File: rtl/char_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : char_line_buffer
//  Purpose  : Producer side of the character-slot interface read by the VGA
//             text renderer. Accepts an ASCII byte stream over valid/ready,
//             edits a line in a private edit buffer and copies it to the
//             display buffer only on a frame_start pulse after a commit (CR),
//             so the renderer never shows a half-updated line.
//  Ports    : clk          system clock
//             rst_n        asynchronous active-low reset
//             in_valid     in_char is valid
//             in_ready     byte can be accepted this cycle (state only)
//             in_char      ASCII byte
//             frame_start  one-cycle pulse at start of vertical blanking
//             character    display buffer, slot 0 leftmost, 8'h00 = empty
//             count        filled slots in the edit buffer (0..SLOTS)
//             pending      commit requested, waiting for frame_start
//             reject       one-cycle pulse: an accepted byte was dropped
//  Revision : 1.0  initial release
// ============================================================================
module char_line_buffer #(
    parameter int SLOTS           = 11,
    parameter int CHAR_W          = 8,
    parameter bit CLEAR_ON_COMMIT = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CHAR_W-1:0]             in_char,
    input  logic                          frame_start,
    output logic [SLOTS-1:0][CHAR_W-1:0]  character,
    output logic [3:0]                    count,
    output logic                          pending,
    output logic                          reject
);

    localparam logic [3:0]        c_SLOTS  = 4'(SLOTS);
    localparam logic [CHAR_W-1:0] c_BS     = CHAR_W'(8'h08);
    localparam logic [CHAR_W-1:0] c_ESC    = CHAR_W'(8'h1B);
    localparam logic [CHAR_W-1:0] c_CR     = CHAR_W'(8'h0D);
    localparam logic [CHAR_W-1:0] c_LC_LO  = CHAR_W'(8'h61);
    localparam logic [CHAR_W-1:0] c_LC_HI  = CHAR_W'(8'h7A);
    localparam logic [CHAR_W-1:0] c_CASE   = CHAR_W'(8'h20);
    localparam logic [CHAR_W-1:0] c_DIG_LO = CHAR_W'(8'h30);
    localparam logic [CHAR_W-1:0] c_DIG_HI = CHAR_W'(8'h39);
    localparam logic [CHAR_W-1:0] c_UC_LO  = CHAR_W'(8'h41);
    localparam logic [CHAR_W-1:0] c_UC_HI  = CHAR_W'(8'h5A);

    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_PEND   = 1'b1
    } state_t;

    state_t                         r_state;
    logic [SLOTS-1:0][CHAR_W-1:0]   r_edit;
    logic [CHAR_W-1:0]              w_code;
    logic                           w_printable;

    // Lowercase folds to uppercase before classification, so every mapped
    // letter lands in the printable uppercase range.
    always_comb begin
        w_code = in_char;
        if (in_char >= c_LC_LO && in_char <= c_LC_HI) begin
            w_code = in_char - c_CASE;
        end
        w_printable = (w_code >= c_DIG_LO && w_code <= c_DIG_HI) ||
                      (w_code >= c_UC_LO  && w_code <= c_UC_HI);
    end

    assign in_ready = (r_state == ST_ACCEPT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_ACCEPT;
            r_edit    <= '0;
            character <= '0;
            count     <= '0;
            pending   <= 1'b0;
            reject    <= 1'b0;
        end else begin
            reject <= 1'b0;
            if (r_state == ST_ACCEPT) begin
                // frame_start is deliberately ignored here: a commit on the
                // same edge as frame_start waits for the next frame.
                if (in_valid) begin
                    if (w_printable) begin
                        if (count < c_SLOTS) begin
                            r_edit[count] <= w_code;
                            count         <= count + 4'd1;
                        end else begin
                            reject <= 1'b1;
                        end
                    end else if (in_char == c_BS) begin
                        if (count != 4'd0) begin
                            r_edit[count - 4'd1] <= '0;
                            count                <= count - 4'd1;
                        end
                    end else if (in_char == c_ESC) begin
                        r_edit <= '0;
                        count  <= '0;
                    end else if (in_char == c_CR) begin
                        r_state <= ST_PEND;
                        pending <= 1'b1;
                    end else begin
                        reject <= 1'b1;
                    end
                end
            end else begin
                // Edits are frozen while pending; the whole line moves to the
                // display in a single edge.
                if (frame_start) begin
                    character <= r_edit;
                    if (CLEAR_ON_COMMIT) begin
                        r_edit <= '0;
                        count  <= '0;
                    end
                    r_state <= ST_ACCEPT;
                    pending <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_char_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_char_line_buffer
//  Purpose  : Self-checking bench for char_line_buffer. A driver issues one
//             stimulus cycle at a time, advances a queue-based line model and
//             pushes the expected post-edge outputs; a monitor pops and
//             compares them after each clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_char_line_buffer;

    localparam int SLOTS = 11;

    logic                     clk;
    logic                     rst_n;
    logic                     in_valid;
    logic                     in_ready;
    logic [7:0]               in_char;
    logic                     frame_start;
    logic [SLOTS-1:0][7:0]    character;
    logic [3:0]               count;
    logic                     pending;
    logic                     reject;

    char_line_buffer #(.SLOTS(SLOTS), .CHAR_W(8), .CLEAR_ON_COMMIT(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .frame_start(frame_start),
        .character  (character),
        .count      (count),
        .pending    (pending),
        .reject     (reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int                    tag;
        logic [3:0]            cnt;
        logic                  pend;
        logic                  rej;
        logic                  rdy;
        logic [SLOTS-1:0][7:0] disp;
    } exp_t;

    exp_t                  sb[$];
    logic [7:0]            m_line[$];
    logic [SLOTS-1:0][7:0] m_disp;
    logic                  m_pend;

    task automatic model_reset();
        m_line.delete();
        m_disp = '0;
        m_pend = 1'b0;
    endtask

    function automatic bit is_printable(input logic [7:0] c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "Z");
    endfunction

    // Drive one cycle of stimulus (called at posedge+1), predict the outputs
    // after the coming edge, and advance to the next posedge+1.
    task automatic step(input logic v, input logic [7:0] c, input logic fs);
        exp_t       e;
        logic [7:0] code;
        bit         rej;
        bit         xfer;
        bit         copy;
        in_valid    = v;
        in_char     = c;
        frame_start = fs;
        rej  = 0;
        xfer = v && !m_pend;
        copy = fs && m_pend;
        if (copy) begin
            for (int i = 0; i < SLOTS; i++)
                m_disp[i] = (i < m_line.size()) ? m_line[i] : 8'h00;
            m_line.delete();
            m_pend = 1'b0;
        end
        if (xfer) begin
            code = (c >= "a" && c <= "z") ? c - 8'd32 : c;
            if (is_printable(code)) begin
                if (m_line.size() < SLOTS) m_line.push_back(code);
                else rej = 1;
            end else if (c == 8'h08) begin
                if (m_line.size() > 0) void'(m_line.pop_back());
            end else if (c == 8'h1B) begin
                m_line.delete();
            end else if (c == 8'h0D) begin
                m_pend = 1'b1;
            end else begin
                rej = 1;
            end
        end
        e.tag  = cyc + 1;
        e.cnt  = 4'(m_line.size());
        e.pend = m_pend;
        e.rej  = rej;
        e.rdy  = !m_pend;
        e.disp = m_disp;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        step(1'b1, c, 1'b0);
    endtask

    task automatic idle(input int n, input logic fs);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, fs);
    endtask

    function automatic logic [7:0] rand_char();
        case ($urandom_range(0, 9))
            0, 1:    return 8'("0") + 8'($urandom_range(0, 9));
            2, 3:    return 8'("A") + 8'($urandom_range(0, 25));
            4:       return 8'("a") + 8'($urandom_range(0, 25));
            5:       return 8'h08;
            6:       return 8'h1B;
            7:       return 8'h0D;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // ---------------- monitor ----------------
    initial begin
        exp_t r;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            while (sb.size() > 0 && sb[0].tag <= cyc) begin
                r = sb.pop_front();
                if (r.tag != cyc) begin
                    chk("sb_tag", 128'(r.tag), 128'(cyc));
                end else begin
                    chk("count",     128'(count),     128'(r.cnt));
                    chk("pending",   128'(pending),   128'(r.pend));
                    chk("reject",    128'(reject),    128'(r.rej));
                    chk("in_ready",  128'(in_ready),  128'(r.rdy));
                    chk("character", 128'(character), 128'(r.disp));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_char     = 8'h00;
        frame_start = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count",     128'(count),     128'(0));
        chk("rst_pending",   128'(pending),   128'(0));
        chk("rst_reject",    128'(reject),    128'(0));
        chk("rst_ready",     128'(in_ready),  128'(1));
        chk("rst_character", 128'(character), 128'(0));
        rst_n = 1'b1;

        // Basic line and commit with case folding.
        send("A"); send("b"); send("7"); send(8'h0D);
        idle(2, 1'b0); idle(1, 1'b1); idle(1, 1'b0);

        // Overfill: 12th byte rejected.
        for (int i = 0; i < 12; i++) send("Z");
        idle(2, 1'b1);
        send(8'h1B);

        // Backspace underflow and escape.
        send("1"); send("2"); send(8'h08); send(8'h08); send(8'h08);
        send("Q"); send("R"); send(8'h1B); send("X");

        // Commit on the same edge as frame_start: copy waits a frame.
        step(1'b1, 8'h0D, 1'b1);
        idle(3, 1'b0); idle(1, 1'b1); idle(1, 1'b0);

        // Junk codes and valid held through PEND.
        send(8'h3A); send(8'h7F); send("q"); send(8'h0D);
        for (int i = 0; i < 3; i++) send("W");
        step(1'b1, "W", 1'b1);
        send("W");
        send(8'h1B);

        // Randomized traffic.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 9) < 7, rand_char(), $urandom_range(0, 9) == 0);
        idle(1, 1'b1);
        idle(1, 1'b0);
        send(8'h1B);

        // Asynchronous reset while pending.
        send("H"); send("I"); send(8'h0D); send(8'h0D); idle(1, 1'b1);
        send("J"); send(8'h0D); idle(2, 1'b0);
        #3;
        chk("pre_rst_drain", 128'(sb.size()), 128'(0));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_count",     128'(count),     128'(0));
        chk("arst_pending",   128'(pending),   128'(0));
        chk("arst_reject",    128'(reject),    128'(0));
        chk("arst_ready",     128'(in_ready),  128'(1));
        chk("arst_character", 128'(character), 128'(0));
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 128'(in_ready), 128'(1));
        send("k"); send("5"); send(8'h0D); idle(1, 1'b1); idle(1, 1'b0);

        #3;
        for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
        #3;
        chk("sb_drain", 128'(sb.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
